// File: rtl/spi_master_fifo.sv
// -----------------------------------------------------------------------------
// spi_master_fifo
//   SPI master with TX and RX word FIFOs. The host pushes words into the TX
//   FIFO. Each word is shifted out MSB first, and the word captured from MISO
//   is pushed into the RX FIFO. CPOL, CPHA, clock divider, slave select and
//   hold-SS are latched at the start of every word.
//
//   Ports
//     clk_clk, reset_reset_n          system clock, async active-low reset
//     tx_data/tx_valid/tx_ready       TX FIFO push (ready = not full)
//     rx_data/rx_valid/rx_ready       RX FIFO head and pop (valid = not empty)
//     cfg_cpol, cfg_cpha              SPI mode
//     cfg_div                         SCLK half-period = cfg_div+1 clocks
//     cfg_ss, cfg_hold_ss             slave index; keep SS low between words
//     spi_SCLK/MOSI/MISO/SS_n         SPI bus
//     busy                            FSM not idle
//     rx_ovf                          one-cycle pulse: word dropped, RX full
// -----------------------------------------------------------------------------

// Small synchronous FIFO. Depth must be a power of two so the pointers wrap
// naturally. The head is shown combinationally and reads as zero when empty.
module spi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from r_count,
  // and resetting the array would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

module spi_master_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int NUM_SS     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [7:0]        cfg_div,
  input  logic [SS_W-1:0]   cfg_ss,
  input  logic              cfg_hold_ss,
  output logic              spi_SCLK,
  output logic              spi_MOSI,
  input  logic              spi_MISO,
  output logic [NUM_SS-1:0] spi_SS_n,
  output logic              busy,
  output logic              rx_ovf
);
  localparam int            EW        = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, RELEASE} state_t;

  state_t             r_state, w_state_next;
  logic               w_tx_pop, w_load, w_edge, w_word_done, w_half_done;
  logic               w_sample, w_shift, w_odd_edge, w_ss_active;
  logic               w_tx_empty, w_tx_full, w_rx_full, w_rx_empty;
  logic [DATA_W-1:0]  w_tx_head;
  logic [NUM_SS-1:0]  w_ss_n;

  logic [7:0]         r_div, r_cnt;
  logic               r_cpol, r_cpha, r_hold, r_sclk, r_rx_ovf;
  logic [SS_W-1:0]    r_ss;
  logic [DATA_W-1:0]  r_tx_sr, r_rx_sr;
  logic [EW-1:0]      r_edge_cnt;

  spi_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // A word finishing while RX is full is dropped; the FIFO also ignores a
  // push when full, so the gate here only documents the intent.
  spi_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (w_word_done && !w_rx_full),
    .i_data  (r_rx_sr),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign tx_ready    = !w_tx_full;
  assign rx_valid    = !w_rx_empty;
  assign busy        = (r_state != IDLE);
  assign spi_SCLK    = r_sclk;
  assign spi_MOSI    = r_tx_sr[DATA_W-1];
  assign rx_ovf      = r_rx_ovf;
  assign w_half_done = (r_cnt == r_div);

  // Edge numbering starts at 1, so an even edge count means the next edge is
  // odd. CPHA=0 samples on odd edges, CPHA=1 on even edges; the other edges
  // shift. With CPHA=1 the MSB is already on MOSI from SETUP, so the first
  // shift edge leaves it in place.
  assign w_odd_edge = ~r_edge_cnt[0];
  assign w_sample   = w_edge && (w_odd_edge ^ r_cpha);
  assign w_shift    = w_edge && !(w_odd_edge ^ r_cpha) &&
                      !(r_cpha && (r_edge_cnt == '0));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_state_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_load       = 1'b0;
    w_edge       = 1'b0;
    w_word_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_load       = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        // The first SCLK edge opens the first XFER half-period.
        if (w_half_done) begin
          w_edge       = 1'b1;
          w_state_next = XFER;
        end
      end
      XFER: begin
        if (w_half_done) begin
          if (r_edge_cnt == LAST_EDGE) begin
            w_word_done  = 1'b1;
            w_state_next = GAP;
          end else begin
            w_edge = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_half_done) begin
          if (r_hold && !w_tx_empty && (cfg_ss == r_ss)) begin
            w_tx_pop     = 1'b1;
            w_load       = 1'b1;
            w_state_next = SETUP;
          end else begin
            w_state_next = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (w_half_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_hold     <= 1'b0;
      r_ss       <= '0;
      r_sclk     <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_edge_cnt <= '0;
      r_rx_ovf   <= 1'b0;
    end else begin
      // Every state change happens at a half-period boundary or from IDLE,
      // so clearing here starts each state with a fresh count.
      r_cnt    <= ((r_state == IDLE) || w_half_done) ? '0 : r_cnt + 1'b1;
      r_rx_ovf <= w_word_done && w_rx_full;

      if (w_load) begin
        r_cpol     <= cfg_cpol;
        r_cpha     <= cfg_cpha;
        r_div      <= cfg_div;
        r_ss       <= cfg_ss;
        r_hold     <= cfg_hold_ss;
        r_sclk     <= cfg_cpol;
        r_tx_sr    <= w_tx_head;
        r_rx_sr    <= '0;
        r_edge_cnt <= '0;
      end else begin
        if (r_state == IDLE) r_sclk <= cfg_cpol;
        if (w_edge) begin
          r_sclk     <= ~r_sclk;
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
        if (w_sample) r_rx_sr <= {r_rx_sr[DATA_W-2:0], spi_MISO};
        if (w_shift)  r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  // SS stays low from SETUP through GAP. An out-of-range index matches no
  // line, so the word is still clocked with every select high.
  assign w_ss_active = (r_state == SETUP) || (r_state == XFER) || (r_state == GAP);

  always_comb begin
    w_ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (w_ss_active && (r_ss == SS_W'(i))) w_ss_n[i] = 1'b0;
    end
  end

  assign spi_SS_n = w_ss_n;
endmodule

// File: tb/tb_spi_master_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_master_fifo
//   Directed bench for spi_master_fifo (DATA_W=8, NUM_SS=2, FIFO_DEPTH=4).
//   A negedge monitor logs SCLK rising edges (cycle, MOSI, SS_n), SS_n
//   transitions and rx_ovf pulses. Each scenario task drives stimulus and
//   compares the logged behaviour with hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_master_fifo;
  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       cfg_cpol, cfg_cpha, cfg_hold_ss;
  logic [7:0] cfg_div;
  logic [0:0] cfg_ss;
  logic       spi_SCLK, spi_MOSI, spi_MISO;
  logic [1:0] spi_SS_n;
  logic       busy, rx_ovf;
  logic       loop_en, miso_fix;

  int checks = 0;
  int errors = 0;

  assign spi_MISO = loop_en ? spi_MOSI : miso_fix;

  spi_master_fifo #(.DATA_W(8), .NUM_SS(2), .FIFO_DEPTH(4)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_div       (cfg_div),
    .cfg_ss        (cfg_ss),
    .cfg_hold_ss   (cfg_hold_ss),
    .spi_SCLK      (spi_SCLK),
    .spi_MOSI      (spi_MOSI),
    .spi_MISO      (spi_MISO),
    .spi_SS_n      (spi_SS_n),
    .busy          (busy),
    .rx_ovf        (rx_ovf)
  );

  initial forever #5 clk_clk = ~clk_clk;

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         clr_req = 0, clr_ack = 0;
  int         rise_cyc[$];
  logic       rise_mosi[$];
  logic [1:0] rise_ss[$];
  int         ss_asr_cnt[2], ss_rel_cnt[2], ss_asr_cyc[2], ss_rel_cyc[2], ss_low[2];
  int         multi_low = 0, ovf_cnt = 0, ovf_wide = 0;
  logic       prev_sclk = 1'b0, prev_ovf = 1'b0;
  logic [1:0] prev_ss = 2'b11;

  always @(negedge clk_clk) begin
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      rise_cyc.delete();
      rise_mosi.delete();
      rise_ss.delete();
      for (int i = 0; i < 2; i++) begin
        ss_asr_cnt[i] = 0; ss_rel_cnt[i] = 0;
        ss_asr_cyc[i] = 0; ss_rel_cyc[i] = 0; ss_low[i] = 0;
      end
      ovf_cnt = 0;
      ovf_wide = 0;
    end
    if (spi_SCLK && !prev_sclk) begin
      rise_cyc.push_back(cyc);
      rise_mosi.push_back(spi_MOSI);
      rise_ss.push_back(spi_SS_n);
    end
    prev_sclk = spi_SCLK;
    for (int i = 0; i < 2; i++) begin
      if (!spi_SS_n[i] && prev_ss[i]) begin ss_asr_cnt[i]++; ss_asr_cyc[i] = cyc; end
      if (spi_SS_n[i] && !prev_ss[i]) begin ss_rel_cnt[i]++; ss_rel_cyc[i] = cyc; end
      if (!spi_SS_n[i]) ss_low[i]++;
    end
    prev_ss = spi_SS_n;
    if (spi_SS_n == 2'b00) multi_low++;
    if (rx_ovf) begin
      ovf_cnt++;
      if (prev_ovf) ovf_wide++;
    end
    prev_ovf = rx_ovf;
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic mon_clear();
    clr_req++;
    @(negedge clk_clk);
  endtask

  task automatic set_cfg(input logic pol, input logic pha, input logic [7:0] div,
                         input logic ss, input logic hold);
    cfg_cpol = pol; cfg_cpha = pha; cfg_div = div; cfg_ss = ss; cfg_hold_ss = hold;
  endtask

  task automatic push_word(input logic [7:0] d);
    @(negedge clk_clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_word();
    @(negedge clk_clk);
    rx_ready = 1'b1;
    @(negedge clk_clk);
    rx_ready = 1'b0;
  endtask

  // Idle with an empty TX FIFO shows busy low for several cycles in a row.
  task automatic wait_idle(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      if (!busy) quiet++; else quiet = 0;
      if (quiet >= 3) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      if (rise_cyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_reset_n = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b1; miso_fix = 1'b0;
    set_cfg(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    repeat (2) @(negedge clk_clk);
    checks++; if (spi_SS_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b expected 11", spi_SS_n); end
    checks++; if (spi_SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", spi_SCLK); end
    checks++; if (spi_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", spi_MOSI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL reset_rx_ovf: got %b expected 0", rx_ovf); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    checks++; if (spi_SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk_follow_cpol1: got %b expected 1", spi_SCLK); end
    cfg_cpol = 1'b0;
    @(negedge clk_clk);
    checks++; if (spi_SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk_follow_cpol0: got %b expected 0", spi_SCLK); end
  endtask

  task automatic test_mode0_loopback();
    bit ok;
    int bad_ss = 0;
    logic [7:0] exp_w = 8'hA5;
    set_cfg(1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    loop_en = 1'b1;
    mon_clear();
    push_word(exp_w);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode0_timeout: busy=%b expected idle", busy); end
    checks++; if (rise_cyc.size() !== 8) begin errors++; $display("FAIL mode0_rise_count: got %0d expected 8", rise_cyc.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rise_mosi[k] !== exp_w[7-k]) begin errors++; $display("FAIL mode0_mosi_bit%0d: got %b expected %b", k, rise_mosi[k], exp_w[7-k]); end
      if (rise_ss[k] !== 2'b10) bad_ss++;
    end
    for (int k = 1; k < 8; k++) begin
      checks++; if (rise_cyc[k] - rise_cyc[k-1] !== 4) begin errors++; $display("FAIL mode0_rise_spacing%0d: got %0d expected 4", k, rise_cyc[k] - rise_cyc[k-1]); end
    end
    checks++; if (bad_ss !== 0) begin errors++; $display("FAIL mode0_ss_during_word: %0d rises without SS_n=10, expected 0", bad_ss); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mode0_rx_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL mode0_rx_data: got %h expected a5", rx_data); end
    pop_word();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mode0_rx_empty_after_pop: got %b expected 0", rx_valid); end
  endtask

  task automatic test_mode3();
    bit ok;
    logic [7:0] tx_w = 8'h3C;
    set_cfg(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    loop_en = 1'b0; miso_fix = 1'b1;
    repeat (2) @(negedge clk_clk);
    checks++; if (spi_SCLK !== 1'b1) begin errors++; $display("FAIL mode3_sclk_idle: got %b expected 1", spi_SCLK); end
    mon_clear();
    push_word(tx_w);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode3_timeout: busy=%b expected idle", busy); end
    checks++; if (rise_cyc.size() !== 8) begin errors++; $display("FAIL mode3_rise_count: got %0d expected 8", rise_cyc.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rise_mosi[k] !== tx_w[7-k]) begin errors++; $display("FAIL mode3_mosi_bit%0d: got %b expected %b", k, rise_mosi[k], tx_w[7-k]); end
    end
    checks++; if (rise_cyc[1] - rise_cyc[0] !== 2) begin errors++; $display("FAIL mode3_div0_spacing: got %0d expected 2", rise_cyc[1] - rise_cyc[0]); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL mode3_rx_data: got %h expected ff", rx_data); end
    checks++; if (spi_SS_n !== 2'b11) begin errors++; $display("FAIL mode3_ss_released: got %b expected 11", spi_SS_n); end
    checks++; if (spi_SCLK !== 1'b1) begin errors++; $display("FAIL mode3_sclk_after: got %b expected 1", spi_SCLK); end
    pop_word();
  endtask

  task automatic test_div_max();
    bit ok;
    set_cfg(1'b0, 1'b0, 8'd255, 1'b0, 1'b0);
    loop_en = 1'b1;
    repeat (2) @(negedge clk_clk);
    mon_clear();
    push_word(8'hE7);
    wait_idle(8000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL divmax_timeout: busy=%b expected idle", busy); end
    checks++; if (rise_cyc[1] - rise_cyc[0] !== 512) begin errors++; $display("FAIL divmax_spacing: got %0d expected 512", rise_cyc[1] - rise_cyc[0]); end
    checks++; if (rx_data !== 8'hE7) begin errors++; $display("FAIL divmax_rx_data: got %h expected e7", rx_data); end
    pop_word();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_w [3] = '{8'h11, 8'h22, 8'h33};
    set_cfg(1'b0, 1'b0, 8'd1, 1'b1, 1'b1);
    loop_en = 1'b1;
    mon_clear();
    for (int i = 0; i < 3; i++) push_word(exp_w[i]);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: busy=%b expected idle", busy); end
    checks++; if (rise_cyc.size() !== 24) begin errors++; $display("FAIL b2b_rise_count: got %0d expected 24", rise_cyc.size()); end
    checks++; if (ss_asr_cnt[1] !== 1) begin errors++; $display("FAIL b2b_ss1_asserts: got %0d expected 1", ss_asr_cnt[1]); end
    checks++; if (ss_rel_cnt[1] !== 1) begin errors++; $display("FAIL b2b_ss1_releases: got %0d expected 1", ss_rel_cnt[1]); end
    checks++; if (ss_low[0] !== 0) begin errors++; $display("FAIL b2b_ss0_low_cycles: got %0d expected 0", ss_low[0]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_data !== exp_w[i]) begin errors++; $display("FAIL b2b_rx_word%0d: got %h expected %h", i, rx_data, exp_w[i]); end
      pop_word();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_rx_empty: got %b expected 0", rx_valid); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] w [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0};
    set_cfg(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    loop_en = 1'b1; rx_ready = 1'b0;
    mon_clear();
    // One push per cycle: the first word leaves for the shifter at once, the
    // next four fill the TX FIFO.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      tx_data = w[i]; tx_valid = 1'b1;
    end
    @(negedge clk_clk);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovf_tx_full: tx_ready got %b expected 0", tx_ready); end
    tx_data = 8'h0F;
    @(negedge clk_clk);
    tx_valid = 1'b0;
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout_a: busy=%b expected idle", busy); end
    checks++; if (rise_cyc.size() !== 40) begin errors++; $display("FAIL ovf_ignored_push: rises got %0d expected 40", rise_cyc.size()); end
    checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL ovf_pulse_a: got %0d expected 1", ovf_cnt); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL ovf_head_a: got %h expected 81", rx_data); end
    push_word(8'h77);
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout_b: busy=%b expected idle", busy); end
    checks++; if (ovf_cnt !== 2) begin errors++; $display("FAIL ovf_pulse_b: got %0d expected 2", ovf_cnt); end
    checks++; if (ovf_wide !== 0) begin errors++; $display("FAIL ovf_pulse_width: %0d wide cycles, expected 0", ovf_wide); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL ovf_head_b: got %h expected 81", rx_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_data !== w[i]) begin errors++; $display("FAIL ovf_rx_word%0d: got %h expected %h", i, rx_data, w[i]); end
      pop_word();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_rx_empty: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    set_cfg(1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    loop_en = 1'b1;
    mon_clear();
    push_word(8'h5A);
    wait_rises(3, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_bit3: rises got %0d expected 3", rise_cyc.size()); end
    #2 reset_reset_n = 1'b0;
    #1;
    checks++; if (spi_SS_n !== 2'b11) begin errors++; $display("FAIL rstmid_ss_n: got %b expected 11", spi_SS_n); end
    checks++; if (spi_SCLK !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b expected 0", spi_SCLK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial: rx_valid got %b expected 0", rx_valid); end
    push_word(8'hC3);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: busy=%b expected idle", busy); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_rx_data: got %h expected c3", rx_data); end
    pop_word();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single_word: rx_valid got %b expected 0", rx_valid); end
  endtask

  task automatic test_cfg_change();
    bit ok;
    set_cfg(1'b0, 1'b0, 8'd1, 1'b0, 1'b1);
    loop_en = 1'b1;
    mon_clear();
    push_word(8'h96);
    push_word(8'h69);
    wait_rises(2, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cfgchg_start: rises got %0d expected 2", rise_cyc.size()); end
    cfg_ss = 1'b1;
    cfg_div = 8'd0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cfgchg_timeout: busy=%b expected idle", busy); end
    checks++; if (rise_cyc.size() !== 16) begin errors++; $display("FAIL cfgchg_rise_count: got %0d expected 16", rise_cyc.size()); end
    checks++; if (rise_cyc[7] - rise_cyc[0] !== 28) begin errors++; $display("FAIL cfgchg_word1_timing: got %0d expected 28", rise_cyc[7] - rise_cyc[0]); end
    checks++; if (rise_ss[7] !== 2'b10) begin errors++; $display("FAIL cfgchg_word1_ss: got %b expected 10", rise_ss[7]); end
    checks++; if (rise_cyc[9] - rise_cyc[8] !== 2) begin errors++; $display("FAIL cfgchg_word2_timing: got %0d expected 2", rise_cyc[9] - rise_cyc[8]); end
    checks++; if (rise_ss[12] !== 2'b01) begin errors++; $display("FAIL cfgchg_word2_ss: got %b expected 01", rise_ss[12]); end
    checks++; if (ss_rel_cnt[0] !== 1 || ss_asr_cnt[1] !== 1) begin errors++; $display("FAIL cfgchg_ss_events: ss0 rel %0d ss1 asr %0d expected 1 1", ss_rel_cnt[0], ss_asr_cnt[1]); end
    checks++; if (!(ss_rel_cyc[0] < ss_asr_cyc[1])) begin errors++; $display("FAIL cfgchg_release_first: ss0 released cyc %0d ss1 asserted cyc %0d", ss_rel_cyc[0], ss_asr_cyc[1]); end
    checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL cfgchg_rx_word0: got %h expected 96", rx_data); end
    pop_word();
    checks++; if (rx_data !== 8'h69) begin errors++; $display("FAIL cfgchg_rx_word1: got %h expected 69", rx_data); end
    pop_word();
  endtask

  task automatic test_ss_exclusive();
    checks++; if (multi_low !== 0) begin errors++; $display("FAIL ss_exclusive: %0d cycles with both SS_n low, expected 0", multi_low); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3();
    test_div_max();
    test_back_to_back();
    test_overflow();
    test_reset_mid_word();
    test_cfg_change();
    test_ss_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
